// File: rtl/keypad_debounce_encoder.sv
// keypad_debounce_encoder
// Front end for the code detonator keypad. Synchronises the 15 raw buttons,
// debounces them with one shared FSM and counter, and emits one-cycle
// one-hot key pulses plus the last accepted digit code.
// Optional build macro: KEYPAD_STUCK_DET_EN adds a held-key watchdog
// (key_stuck). Without it key_stuck is tied low.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no key owned; waiting for exactly one key to be down
// PRESS_DB | one key captured; must stay unchanged for DB_CYCLES
// HELD     | pulse issued; waiting for all keys to be released
// REL_DB   | all keys up; must stay up for DB_CYCLES before re-arming

module keypad_debounce_encoder #(
  parameter int DB_CYCLES    = 1_000_000,
  parameter int STUCK_CYCLES = 250_000_000,
  parameter int CNT_W        = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] key_raw,
  output logic [9:0]  digit_pulse,
  output logic [4:0]  func_pulse,
  output logic [3:0]  key_code,
  output logic        busy,
  output logic        key_stuck
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state, state_nxt;
  logic [14:0]       s1, s2;
  logic [14:0]       cap, cap_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              accept;

  function automatic logic is_onehot(input logic [14:0] v);
    return (v != '0) && ((v & (v - 15'd1)) == '0);
  endfunction

  function automatic logic [3:0] digit_index(input logic [9:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Two-flop synchroniser for the asynchronous button levels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
    end
  end

  // Debounce FSM state, captured key and shared window counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cap   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cap   <= cap_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; the counter is cleared on every state change so it never wraps
  always_comb begin
    state_nxt = state;
    cap_nxt   = cap;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (is_onehot(s2)) begin
          cap_nxt   = s2;
          cnt_nxt   = '0;
          state_nxt = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (s2 != cap) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == DB_LAST) begin
          cnt_nxt   = '0;
          state_nxt = HELD;
          accept    = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (s2 == '0) begin
          cnt_nxt   = '0;
          state_nxt = REL_DB;
        end
      end
      REL_DB: begin
        if (s2 != '0) begin
          cnt_nxt   = '0;
          state_nxt = HELD;
        end else if (cnt == DB_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs: pulses last one cycle, key_code only follows digits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_pulse <= '0;
      func_pulse  <= '0;
      key_code    <= '0;
      busy        <= 1'b0;
    end else begin
      digit_pulse <= accept ? cap[9:0]   : '0;
      func_pulse  <= accept ? cap[14:10] : '0;
      if (accept && (cap[9:0] != '0)) key_code <= digit_index(cap[9:0]);
      busy <= (state_nxt != IDLE);
    end
  end

`ifdef KEYPAD_STUCK_DET_EN
  localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);

  logic [CNT_W-1:0] stuck_cnt;

  // Held-key watchdog: counts from entry to HELD until the FSM re-arms in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stuck_cnt <= '0;
      key_stuck <= 1'b0;
    end else if (state_nxt == IDLE) begin
      stuck_cnt <= '0;
      key_stuck <= 1'b0;
    end else if (accept) begin
      stuck_cnt <= '0;
    end else if ((state == HELD) || (state == REL_DB)) begin
      if (stuck_cnt == STUCK_LAST) key_stuck <= 1'b1;
      else                         stuck_cnt <= stuck_cnt + CNT_ONE;
    end
  end
`else
  // Watchdog absent; the comparison only keeps STUCK_CYCLES referenced and folds to 0
  assign key_stuck = (STUCK_CYCLES == 0) && 1'b0;
`endif

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Self-checking bench for keypad_debounce_encoder (DB_CYCLES=4, STUCK_CYCLES=16).
// Reference model works on runs of identical synchronised samples rather
// than on FSM states.
module tb_keypad_debounce_encoder;

  localparam int DB = 4;
  localparam int ST = 16;

  logic        clk;
  logic        rst;
  logic [14:0] key_raw;
  logic [9:0]  digit_pulse;
  logic [4:0]  func_pulse;
  logic [3:0]  key_code;
  logic        busy;
  logic        key_stuck;

  keypad_debounce_encoder #(
    .DB_CYCLES(DB),
    .STUCK_CYCLES(ST),
    .CNT_W(28)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_raw(key_raw),
    .digit_pulse(digit_pulse),
    .func_pulse(func_pulse),
    .key_code(key_code),
    .busy(busy),
    .key_stuck(key_stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_pulses;

  // reference model state
  logic [14:0] d1, d2;
  logic [14:0] run_val;
  int          run_len;
  bit          armed;
  logic [9:0]  exp_digit;
  logic [4:0]  exp_func;
  logic [3:0]  exp_code;
  bit          exp_stuck;
  int          stuck_age;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    d1 = '0; d2 = '0;
    run_val = '0; run_len = 0;
    armed = 1'b1;
    exp_digit = '0; exp_func = '0; exp_code = '0;
    exp_stuck = 1'b0; stuck_age = 0;
  endtask

  // One clock edge: the FSM judges the value that has crossed both sync stages
  task automatic model_edge(input logic [14:0] raw);
    logic [14:0] x;
    bit pulse_now, arm_now;
    x = d2; d2 = d1; d1 = raw;
    exp_digit = '0; exp_func = '0;
    pulse_now = 1'b0; arm_now = 1'b0;
    if (x == run_val) run_len++;
    else begin run_val = x; run_len = 1; end
    if (armed && ($countones(x) == 1) && run_len == DB + 1) begin
      pulse_now = 1'b1;
      armed = 1'b0;
      if (x[9:0] != '0) begin
        exp_digit = x[9:0];
        for (int i = 0; i < 10; i++) if (x[i]) exp_code = 4'(i);
      end else begin
        exp_func = x[14:10];
      end
    end else if (!armed && x == '0 && run_len == DB + 1) begin
      arm_now = 1'b1;
      armed = 1'b1;
    end
`ifdef KEYPAD_STUCK_DET_EN
    if (pulse_now) stuck_age = 0;
    else if (arm_now) begin stuck_age = 0; exp_stuck = 1'b0; end
    else if (!armed) begin
      if (stuck_age == ST - 1) exp_stuck = 1'b1;
      else stuck_age++;
    end
`else
    exp_stuck = 1'b0;
`endif
  endtask

  function automatic bit exp_busy();
    return !armed || (($countones(run_val) == 1) && run_len <= DB);
  endfunction

  task automatic step(input logic [14:0] raw);
    @(negedge clk);
    key_raw = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
    check_eq("digit_pulse", 16'(digit_pulse), 16'(exp_digit));
    check_eq("func_pulse",  16'(func_pulse),  16'(exp_func));
    check_eq("key_code",    16'(key_code),    16'(exp_code));
    check_eq("busy",        16'(busy),        16'(exp_busy()));
    check_eq("key_stuck",   16'(key_stuck),   16'(exp_stuck));
    if ((digit_pulse != '0) || (func_pulse != '0)) n_pulses++;
  endtask

  task automatic hold(input logic [14:0] raw, input int n);
    for (int i = 0; i < n; i++) step(raw);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_digit"}, 16'(digit_pulse), 16'h0);
    check_eq({tag, "_func"},  16'(func_pulse),  16'h0);
    check_eq({tag, "_code"},  16'(key_code),    16'h0);
    check_eq({tag, "_busy"},  16'(busy),        16'h0);
    check_eq({tag, "_stuck"}, 16'(key_stuck),   16'h0);
  endtask

  function automatic logic [14:0] bitv(input int k);
    return 15'(1) << k;
  endfunction

  initial begin
    int seg_n, seg_len, kind, k, w;
    logic [14:0] v;
    rst = 1'b0;
    key_raw = '0;
    model_reset();
    #23;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // clean press of digit 2
    n_pulses = 0;
    hold(bitv(2), 20);
    hold('0, 12);
    check_eq("clean_pulses", 16'(n_pulses), 16'd1);
    check_eq("clean_code", 16'(key_code), 16'd2);

    // bounce on digit 5, then a solid hold
    n_pulses = 0;
    hold(bitv(5), 1); hold('0, 1); hold(bitv(5), 1); hold('0, 1);
    hold(bitv(5), 10);
    hold('0, 12);
    check_eq("bounce_pulses", 16'(n_pulses), 16'd1);
    check_eq("bounce_code", 16'(key_code), 16'd5);

    // two keys together are ignored until one is released
    n_pulses = 0;
    hold(bitv(1) | bitv(3), 20);
    check_eq("multi_no_pulse", 16'(n_pulses), 16'd0);
    hold(bitv(1), 10);
    hold('0, 12);
    check_eq("multi_pulses", 16'(n_pulses), 16'd1);
    check_eq("multi_code", 16'(key_code), 16'd1);

    // digit 8 then the sure function key
    hold(bitv(8), 10);
    hold('0, 12);
    n_pulses = 0;
    hold(bitv(14), 10);
    hold('0, 12);
    check_eq("func_pulses", 16'(n_pulses), 16'd1);
    check_eq("func_code_kept", 16'(key_code), 16'd8);

    // reset while debouncing digit 6, key still held afterwards
    hold(bitv(6), 5);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    n_pulses = 0;
    hold(bitv(6), 10);
    hold('0, 12);
    check_eq("midrst_pulses", 16'(n_pulses), 16'd1);
    check_eq("midrst_code", 16'(key_code), 16'd6);

    // long hold (watchdog path when built in)
    hold(bitv(0), 30);
    hold('0, 12);

    // randomized press episodes with bounce and extra keys
    for (int e = 0; e < 40; e++) begin
      k = $urandom_range(0, 14);
      v = bitv(k);
      seg_n = $urandom_range(1, 6);
      for (int s = 0; s < seg_n; s++) begin
        kind = $urandom_range(0, 3);
        seg_len = $urandom_range(1, 7);
        w = $urandom_range(0, 14);
        case (kind)
          0:       hold('0, seg_len);
          1:       hold(v | bitv(w), seg_len);
          default: hold(v, seg_len);
        endcase
      end
      hold(v, $urandom_range(0, 8));
      hold('0, $urandom_range(1, 8));
    end
    hold('0, 12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
